// File: rtl/countdown_pkg.sv
// Shared state encoding and mode constants for the countdown controller slice.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/countdown_if.sv
// Control/status bundle between the front-end (master) and countdown_ctrl (slave).
interface countdown_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 8
);
  logic [WIDTH-1:0]   load_val;
  logic [PRESC_W-1:0] presc;
  logic               mode;
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   out;
  logic               busy;
  logic               paused;
  logic               done;

  modport master (
    output load_val, presc, mode, start, stop,
    input  out, busy, paused, done
  );

  modport slave (
    input  load_val, presc, mode, start, stop,
    output out, busy, paused, done
  );
endinterface

// File: rtl/countdown_presc.sv
// Prescale counter: tick when pc has reached presc; >= lets a lowered divisor fire at once.
module countdown_presc #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc;

  assign tick = (pc >= presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: IDLE/RUN/PAUSE FSM with registered count and Done pulse.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  countdown_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             clr, en, tick;

  countdown_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .presc (bus.presc),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.load_val == '0) begin
            out_d  = '0;
            done_d = 1'b1;
          end else begin
            out_d   = bus.load_val;
            clr     = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_PAUSE;
        end else begin
          en = 1'b1;
          if (tick) begin
            if (out_q > WIDTH'(1)) begin
              out_d = out_q - WIDTH'(1);
            end else if (out_q == WIDTH'(1)) begin
              out_d  = '0;
              done_d = 1'b1;
              if (bus.mode == MODE_ONESHOT) state_d = ST_IDLE;
            end else if (bus.mode == MODE_RELOAD) begin
              out_d  = bus.load_val;
              done_d = (bus.load_val == '0);
            end else begin
              // Parked at 0 after mode was switched to one-shot: leave quietly.
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  assign bus.out    = out_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.paused = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_countdown_ctrl;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned PRESC_W = 8;

  logic clk;
  logic rst;
  logic chk_on;
  int   n_cmp;
  int   n_bad;

  countdown_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  countdown_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: active/held flags, integer count and prescale position.
  logic m_active, m_hold, m_done;
  int   m_count, m_pc;

  always @(posedge clk or posedge rst) begin
    automatic logic act, hld, dn;
    automatic int   cnt, pcv;
    if (rst) begin
      m_active <= 1'b0;
      m_hold   <= 1'b0;
      m_done   <= 1'b0;
      m_count  <= 0;
      m_pc     <= 0;
    end else begin
      act = m_active; hld = m_hold; cnt = m_count; pcv = m_pc; dn = 1'b0;
      if (!act) begin
        if (bus.start && !bus.stop) begin
          if (bus.load_val == 0) begin
            cnt = 0; dn = 1'b1;
          end else begin
            cnt = int'(bus.load_val); pcv = 0; act = 1'b1;
          end
        end
      end else if (hld) begin
        if (bus.stop) begin
          act = 1'b0; hld = 1'b0; pcv = 0;
        end else if (bus.start) begin
          hld = 1'b0;
        end
      end else if (bus.stop) begin
        hld = 1'b1;
      end else if (pcv >= int'(bus.presc)) begin
        pcv = 0;
        if (cnt > 1) cnt = cnt - 1;
        else if (cnt == 1) begin
          cnt = 0; dn = 1'b1;
          if (!bus.mode) act = 1'b0;
        end else if (bus.mode) begin
          cnt = int'(bus.load_val); dn = (bus.load_val == 0);
        end else begin
          act = 1'b0;
        end
      end else begin
        pcv = pcv + 1;
      end
      m_active <= act; m_hold <= hld; m_count <= cnt; m_pc <= pcv; m_done <= dn;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("model_out",    int'(bus.out),    m_count);
      check("model_busy",   int'(bus.busy),   int'(m_active));
      check("model_paused", int'(bus.paused), int'(m_active && m_hold));
      check("model_done",   int'(bus.done),   int'(m_done));
    end
  end

  task automatic next();
    @(negedge clk);
    #2;
  endtask

  task automatic set_in(input int lv, input int ps, input logic md, input logic st, input logic sp);
    bus.load_val = WIDTH'(lv);
    bus.presc    = PRESC_W'(ps);
    bus.mode     = md;
    bus.start    = st;
    bus.stop     = sp;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (bus.busy && i < budget) begin
      next();
      i++;
    end
    check(name, int'(bus.busy), 0);
  endtask

  int seq_os [7] = '{3, 3, 2, 2, 1, 1, 0};
  int seq_ar [7] = '{2, 1, 0, 2, 1, 0, 2};

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 1'b0;
    rst = 1'b1;
    set_in(0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_out", int'(bus.out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_paused", int'(bus.paused), 0);
    check("rst_done", int'(bus.done), 0);
    next(); next();
    rst = 1'b0;
    chk_on = 1'b1;
    next();

    // Reset mid-run, observed without a clock edge
    set_in(9, 0, 1'b0, 1'b1, 1'b0);
    next();
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.out != 5; i++) next();
    check("rst_mid_reach5", int'(bus.out), 5);
    rst = 1'b1;
    #1;
    check("rst_mid_out", int'(bus.out), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_done", int'(bus.done), 0);
    next();
    rst = 1'b0;
    next();

    // One-shot
    set_in(3, 1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      next();
      bus.start = 1'b0;
      check("os_out", int'(bus.out), seq_os[i]);
      check("os_done", int'(bus.done), (i == 6) ? 1 : 0);
      check("os_busy", int'(bus.busy), (i == 6) ? 0 : 1);
    end
    next();
    check("os_done_clear", int'(bus.done), 0);

    // Auto-reload
    set_in(2, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      next();
      bus.start = 1'b0;
      check("ar_out", int'(bus.out), seq_ar[i]);
      check("ar_done", int'(bus.done), (i == 2 || i == 5) ? 1 : 0);
      check("ar_busy", int'(bus.busy), 1);
    end
    bus.stop = 1'b1;
    next(); next();
    bus.stop = 1'b0;
    check("ar_abort_busy", int'(bus.busy), 0);
    next();

    // Pause/resume preserves residual prescale count
    set_in(5, 3, 1'b0, 1'b1, 1'b0);
    next();
    bus.start = 1'b0;
    repeat (6) next();
    bus.stop = 1'b1;
    next();
    bus.stop = 1'b0;
    check("pr_paused", int'(bus.paused), 1);
    check("pr_out", int'(bus.out), 4);
    for (int i = 0; i < 10; i++) begin
      next();
      check("pr_frozen", int'(bus.out), 4);
    end
    bus.start = 1'b1;
    next();
    bus.start = 1'b0;
    check("pr_resume_paused", int'(bus.paused), 0);
    next();
    check("pr_r1", int'(bus.out), 4);
    next();
    check("pr_r2", int'(bus.out), 3);
    wait_idle("pr_finish", 40);
    next();

    // Start&Stop in IDLE stays idle
    set_in(6, 0, 1'b0, 1'b1, 1'b1);
    next();
    check("ss_idle_busy", int'(bus.busy), 0);
    check("ss_idle_out", int'(bus.out), 0);
    // Start ignored in RUN, abort from PAUSE
    set_in(7, 2, 1'b0, 1'b1, 1'b0);
    next();
    bus.load_val = 4'd12;
    next();
    bus.start = 1'b0;
    check("run_start_ignored", int'(bus.out), 7);
    bus.stop = 1'b1;
    next();
    check("abort_paused", int'(bus.paused), 1);
    next();
    bus.stop = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_out", int'(bus.out), 7);
    check("abort_done", int'(bus.done), 0);
    next();

    // Load_val==0
    set_in(0, 0, 1'b0, 1'b1, 1'b0);
    next();
    bus.start = 1'b0;
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    check("zero_out", int'(bus.out), 0);
    next();
    check("zero_done_clear", int'(bus.done), 0);

    // Presc lowered 200 -> 1 at pc=50
    set_in(3, 200, 1'b0, 1'b1, 1'b0);
    next();
    bus.start = 1'b0;
    repeat (50) next();
    check("pl_before", int'(bus.out), 3);
    bus.presc = 8'd1;
    next();
    check("pl_tick", int'(bus.out), 2);
    next();
    check("pl_hold", int'(bus.out), 2);
    next();
    check("pl_next", int'(bus.out), 1);
    wait_idle("pl_finish", 10);
    next();

    // Randomized run, model checked every cycle
    for (int c = 0; c < 3000; c++) begin
      if (!m_active && ($urandom_range(0, 7) == 0)) bus.mode = 1'($urandom_range(0, 1));
      bus.load_val = WIDTH'($urandom_range(0, 15));
      bus.presc    = PRESC_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3));
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.stop     = ($urandom_range(0, 11) == 0);
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
